// File: rtl/alu10_pkg.sv
// Shared opcode, state and width definitions for the alu_seq10 execute stage.
package alu10_pkg;
    localparam int DATA_W = 10;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_SBB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ALU  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/adder10.sv
// 10-bit ripple-carry adder shared by the add/sub and multiply paths.
module adder10 (
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic       cin,
    output logic [9:0] sum,
    output logic       cout
);
    logic [10:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 10; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[10];
endmodule

// File: rtl/alu_seq10.sv
// Sequencing execute stage: single-pass add/sub ops and a shift-add multiply,
// all driven through one adder10, with valid/ready on both sides.
module alu_seq10
    import alu10_pkg::*;
#(
    parameter int DATA_W    = alu10_pkg::DATA_W,
    parameter int OP_W      = 3,
    parameter int MUL_ITERS = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v
);
    localparam int MSB = DATA_W - 1;
    localparam int CNT_W = $clog2(MUL_ITERS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    state_t state, state_nxt;

    // m_r holds operand B for ALU ops and the multiplier/low product for MUL
    logic [DATA_W-1:0] a_r, m_r, p_r;
    logic [OP_W-1:0]   op_r;
    logic              c_lat;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] add_a, add_b, sum;
    logic              add_cin, cout;
    logic [DATA_W-1:0] p_nxt, m_nxt;
    logic              mul_last;

    adder10 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign mul_last  = (cnt == CNT_LAST);
    assign p_nxt     = {cout, sum[MSB:1]};
    assign m_nxt     = {sum[0], m_r[MSB:1]};

    always_comb begin
        add_a   = a_r;
        add_b   = m_r;
        add_cin = 1'b0;
        if (state == ST_MUL) begin
            add_a = p_r;
            add_b = m_r[0] ? a_r : '0;
        end else begin
            case (op_r)
                OP_ADC: add_cin = c_lat;
                OP_SUB: begin add_b = ~m_r; add_cin = 1'b1;  end
                OP_SBB: begin add_b = ~m_r; add_cin = c_lat; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid) state_nxt = (op == OP_MUL) ? ST_MUL : ST_ALU;
            ST_ALU:  state_nxt = ST_DONE;
            ST_MUL:  if (mul_last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            m_r       <= '0;
            p_r       <= '0;
            op_r      <= '0;
            c_lat     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            result_hi <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    a_r   <= a;
                    m_r   <= b;
                    p_r   <= '0;
                    cnt   <= '0;
                    c_lat <= flag_c;
                    // reserved opcodes fold to ADD at accept
                    op_r  <= (op > OP_MUL) ? OP_ADD : op;
                end
                ST_ALU: begin
                    result    <= sum;
                    result_hi <= '0;
                    flag_c    <= cout;
                    flag_z    <= (sum == '0);
                    flag_n    <= sum[MSB];
                    flag_v    <= (a_r[MSB] == add_b[MSB]) && (sum[MSB] != a_r[MSB]);
                end
                ST_MUL: begin
                    p_r <= p_nxt;
                    m_r <= m_nxt;
                    cnt <= cnt + 1'b1;
                    if (mul_last) begin
                        result    <= m_nxt;
                        result_hi <= p_nxt;
                        flag_c    <= (p_nxt != '0);
                        flag_z    <= (m_nxt == '0);
                        flag_n    <= m_nxt[MSB];
                        flag_v    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq10.sv
// Self-checking bench for alu_seq10: directed plan cases, multiply stall,
// mid-multiply reset abort and randomized ops against an arithmetic model.
module tb_alu_seq10;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = '0;
    logic [9:0] a = '0;
    logic [9:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] result, result_hi;
    logic       flag_c, flag_z, flag_n, flag_v;

    int   checks = 0;
    int   failures = 0;
    logic model_c = 1'b0;

    alu_seq10 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    // packed view: {result_hi, result, C, Z, N, V}
    function automatic logic [23:0] obs();
        return {result_hi, result, flag_c, flag_z, flag_n, flag_v};
    endfunction

    function automatic logic [23:0] ref_op(input logic [2:0] o, input logic [9:0] x, y, input logic ci);
        int ua, ub, sa, sb, t, st, brw, prod;
        logic [9:0] r, rh;
        logic c, v;
        ua = int'(x); ub = int'(y);
        sa = x[9] ? ua - 1024 : ua;
        sb = y[9] ? ub - 1024 : ub;
        rh = '0;
        v  = 1'b0;
        case (o)
            3'd1: begin t = ua + ub + int'(ci); st = sa + sb + int'(ci); end
            3'd2: begin t = ua + 1024 - ub; st = sa - sb; end
            3'd3: begin brw = ci ? 0 : 1; t = ua + 1024 - ub - brw; st = sa - sb - brw; end
            3'd4: begin prod = ua * ub; t = 0; st = 0; end
            default: begin t = ua + ub; st = sa + sb; end
        endcase
        if (o == 3'd4) begin
            r  = 10'(prod);
            rh = 10'(prod >> 10);
            c  = (rh != 0);
        end else begin
            r = 10'(t);
            c = (t >= 1024);
            v = (st > 511) || (st < -512);
        end
        return {rh, r, c, (r == 0), r[9], v};
    endfunction

    task automatic issue(input logic [2:0] o, input logic [9:0] x, y,
                         output int lat, output bit busy_ok, output bit acc_ok);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin @(negedge clk); w++; end
        acc_ok = in_ready;
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'($urandom_range(0, 1));
            op = 3'($urandom); a = 10'($urandom); b = 10'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_ok = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic retire(input int hold, output bit stable_ok);
        logic [23:0] snap;
        snap = obs();
        stable_ok = 1'b1;
        out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || obs() !== snap) stable_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== 24'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %h valid=%b want 000000 valid=0", obs(), out_valid);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        model_c = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [7] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd2};
        logic [9:0]  as  [7] = '{10'h004, 10'h3FF, 10'h000, 10'h005, 10'h003, 10'h1FF, 10'h000};
        logic [9:0]  bs  [7] = '{10'h004, 10'h001, 10'h000, 10'h005, 10'h001, 10'h001, 10'h001};
        logic [23:0] exp [7] = '{{10'h0, 10'h008, 4'b0000}, {10'h0, 10'h000, 4'b1100},
                                 {10'h0, 10'h001, 4'b0000}, {10'h0, 10'h000, 4'b1100},
                                 {10'h0, 10'h002, 4'b1000}, {10'h0, 10'h200, 4'b0011},
                                 {10'h0, 10'h3FF, 4'b0010}};
        int lat; bit busy_ok, acc_ok, st_ok;
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], as[i], bs[i], lat, busy_ok, acc_ok);
            checks++;
            if (obs() !== exp[i]) begin
                failures++;
                $display("FAIL directed_%0d: got %h want %h", i, obs(), exp[i]);
            end
            checks++;
            if (lat !== 1 || !busy_ok || !acc_ok) begin
                failures++;
                $display("FAIL directed_lat_%0d: got lat=%0d busy_ok=%0d acc=%0d want lat=1 busy_ok=1 acc=1",
                         i, lat, busy_ok, acc_ok);
            end
            retire(0, st_ok);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL directed_hs_%0d: got valid=%b ready=%b want 0 1", i, out_valid, in_ready);
            end
            model_c = exp[i][3];
        end
    endtask

    task automatic test_mul_stall();
        int lat; bit busy_ok, acc_ok, st_ok;
        issue(3'd4, 10'h3FF, 10'h3FF, lat, busy_ok, acc_ok);
        checks++;
        if (obs() !== {10'h3FE, 10'h001, 4'b1000}) begin
            failures++;
            $display("FAIL mul_result: got %h want %h", obs(), {10'h3FE, 10'h001, 4'b1000});
        end
        checks++;
        if (lat !== 10 || !busy_ok || !acc_ok) begin
            failures++;
            $display("FAIL mul_latency: got lat=%0d busy_ok=%0d want lat=10 busy_ok=1", lat, busy_ok);
        end
        retire(3, st_ok);
        checks++;
        if (!st_ok) begin
            failures++;
            $display("FAIL mul_stall_stable: got stable=%0d want 1", st_ok);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mul_hs: got valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        model_c = 1'b1;
    endtask

    task automatic test_abort();
        int lat; bit busy_ok, acc_ok, st_ok, quiet;
        @(negedge clk);
        op = 3'd4; a = 10'h155; b = 10'h0AA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs() !== 24'h0) begin
            failures++;
            $display("FAIL abort_clear: got valid=%b out=%h want 0 000000", out_valid, obs());
        end
        @(negedge clk); rst_n = 1'b1;
        model_c = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL abort_no_partial: got quiet=%0d want 1", quiet);
        end
        issue(3'd0, 10'h007, 10'h003, lat, busy_ok, acc_ok);
        checks++;
        if (obs() !== {10'h0, 10'h00A, 4'b0000} || lat !== 1 || !acc_ok) begin
            failures++;
            $display("FAIL abort_next_add: got %h lat=%0d want %h lat=1", obs(), lat, {10'h0, 10'h00A, 4'b0000});
        end
        retire(0, st_ok);
    endtask

    task automatic test_random();
        int lat; bit busy_ok, acc_ok, st_ok;
        logic [2:0] o; logic [9:0] x, y; logic [23:0] e;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = 10'($urandom);
            y = 10'($urandom);
            if (i % 5 == 0) y = 10'h3FF - x;
            e = ref_op(o, x, y, model_c);
            issue(o, x, y, lat, busy_ok, acc_ok);
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL random_%0d op=%0d a=%h b=%h cin=%b: got %h want %h", i, o, x, y, model_c, obs(), e);
            end
            checks++;
            if (lat !== ((o == 3'd4) ? 10 : 1) || !busy_ok || !acc_ok) begin
                failures++;
                $display("FAIL random_lat_%0d: got lat=%0d busy_ok=%0d op=%0d", i, lat, busy_ok, o);
            end
            retire($urandom_range(0, 2), st_ok);
            checks++;
            if (!st_ok || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL random_hs_%0d: got stable=%0d valid=%b ready=%b want 1 0 1", i, st_ok, out_valid, in_ready);
            end
            model_c = e[3];
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul_stall();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq10.md
Name: alu_seq10

Overview:
- Sequencing execute stage that sits directly upstream of the team's 10-bit ripple adder (adder10).
- Accepts an opcode and two 10-bit operands from decode over a valid/ready handshake, and drives the single adder10 instance it contains.
- Supports single-pass add/subtract ops and a multi-cycle shift-add multiply.
- Registers the result and the C/Z/N/V flags, then presents them to writeback over a second valid/ready handshake.

Parameters:
- DATA_W, 10, datapath width; only 10 is supported because it must match adder10.
- OP_W, 3, opcode width.
- MUL_ITERS, 10, multiply iteration count; always equals DATA_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  stage can accept; high exactly when state is IDLE.
- op  in  3  opcode: 000 ADD, 001 ADC, 010 SUB, 011 SBB, 100 MUL; 101–111 reserved.
- a  in  10  operand A.
- b  in  10  operand B.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  writeback accepts the result.
- result  out  10  result (for MUL, low half of the product).
- result_hi  out  10  MUL high half; 0 for all other ops.
- flag_c, flag_z, flag_n, flag_v  out  1 each  carry, zero, negative, overflow flags.

Behaviour:
- Reset (asynchronous, active-low):
  - state goes to IDLE.
  - out_valid, result, result_hi, all flags and all internal operand registers clear to 0.
  - Reset asserted mid-operation aborts the operation immediately; no partial result is ever presented.
- States: IDLE, ALU, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0: latch a, b, op and the current flag_c.
  - Next state is MUL for op 100; ALU for every other op.
  - Reserved opcodes execute as ADD.
- ALU (one cycle):
  - Adder inputs are A and B' with carry-in cin:
    - ADD: B'=B, cin=0.
    - ADC: B'=B, cin=latched C.
    - SUB: B'=~B, cin=1.
    - SBB: B'=~B, cin=latched C.
  - Carry uses not-borrow convention: C=1 means no borrow.
  - At edge E1, register:
    - result = sum, result_hi = 0.
    - C = cout, Z = (sum==0), N = sum[9].
    - V = (A[9]==B'[9]) && (sum[9]!=A[9]).
  - Go to DONE.
- MUL (unsigned shift-add, hi accumulator P=0, multiplier in lo register M=B):
  - Each edge E1..E10 performs one iteration:
    - {c,s} = M[0] ? P+A : {0,P}.
    - {P,M} = {c,s,M} >> 1.
  - The adder is reused for every iteration; the iteration counter counts 0..9.
  - After E10: result = M, result_hi = P.
  - Flags: C = (P!=0), Z = (M==0), N = M[9], V = 0.
  - Go to DONE.
- DONE:
  - out_valid=1; result, result_hi and flags stay stable.
  - On out_valid && out_ready, go to IDLE at that edge; out_valid falls the same edge.
- Latency: out_valid rises after E1 (ALU ops) or after E10 (MUL). Earliest next accept is the cycle after the DONE handshake.
- No overlap of operations; in_ready=0 in ALU, MUL and DONE.
- in_valid is ignored outside IDLE.
- Flags persist between operations; ADC/SBB use the flag value latched at accept, not any later value.
- Operand/op changes on the input ports after accept have no effect.

Decomposition:
- Shared package alu10_pkg holds:
  - opcode constants (OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_MUL).
  - state encoding typedef.
  - DATA_W.
- Single sub-module: the existing adder10, instantiated once. Operand muxing, inversion and carry-in selection live in alu_seq10.
- No further sub-modules.

Test Plan:
1. Reset, then ADD a=0x004 b=0x004 -> result 0x008, C0 Z0 N0 V0; out_valid high after E1, in_ready 0 until the DONE handshake.
2. ADD 0x3FF+0x001 -> result 0x000, C1 Z1. Then ADC 0x000+0x000 -> result 0x001, C0.
3. SUB 0x005−0x005 -> result 0x000, Z1 C1. Then SBB 0x003−0x001 with C=1 -> result 0x002, C1.
4. ADD 0x1FF+0x001 -> result 0x200, N1 V1 C0 Z0. Then SUB 0x000−0x001 -> result 0x3FF, C0 N1 V0.
5. MUL 0x3FF×0x3FF:
   - Expect result 0x001, result_hi 0x3FE, C1.
   - out_valid rises exactly 10 edges after accept.
   - Hold out_ready low 3 cycles: outputs stay stable and in_ready stays 0.
6. Start MUL 0x155×0x0AA and assert rst_n low after the 5th iteration:
   - Immediately: out_valid 0, all flags 0, result 0.
   - After release: in_ready 1; ADD 0x007+0x003 -> result 0x00A, correct flags.
